keypad_bcd_encoder: RTL and testbench
=====================================

// Module: keypad_bcd_encoder
// PURPOSE
//  Input-side counterpart of the BCD-to-display path. Scans a 4x4 matrix keypad and debounces key presses.
//  Encodes each accepted press to a 4-bit key code and shifts digit keys into a two-digit BCD register.
//  bcd_t/bcd_u connect directly to the display decoder's tens/units BCD inputs.
//  The scan rate comes from a freq_div-derived tick (scan_tick); all logic runs on clk.
// PARAMETERS
//  DEB_TICKS  3  consecutive scan ticks with identical key required to accept a press (1..15)
// PORTS
//  clk        in   1  system clock (oscillator)
//  rst        in   1  synchronous reset, active-high
//  scan_tick  in   1  one-clk enable pulse; all FSM/row activity advances only when high
//  col_n      in   4  keypad columns, active-low (pulled up; low = key in driven row)
//  row_n      out  4  keypad row drive, one-cold; exactly one bit low at all times
//  key_code   out  4  code of last accepted key (mapping below)
//  key_valid  out  1  one-clk pulse when a press is accepted
//  key_held   out  1  high while accepted key remains pressed (state HELD)
//  bcd_u      out  4  units digit of entry register (0..9)
//  bcd_t      out  4  tens digit of entry register (0..9)
// BEHAVIOUR
//  Reset (sync, any state): row_n=4'b1110, state=SCAN, deb_cnt=0, key_code=0, key_valid=0, bcd_u=bcd_t=0.
//  Key map (row r = index of low row_n bit, c = lowest-index low col_n bit):
//   r0: c0..3 = 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
//   Multiple cols low: lowest col index wins; other cols ignored.
//  FSM, all transitions only on clk edges with scan_tick=1:
//   SCAN: col_n==4'hF -> rotate row (1110->1101->1011->0111->1110).
//         Else latch cand=map(r,c), deb_cnt=1, hold row, go DEBOUNCE.
//         DEB_TICKS==1: accept in the same edge and go HELD directly.
//   DEBOUNCE: row frozen. map(r,c)==cand and col_n!=F -> deb_cnt+1.
//         When deb_cnt+1==DEB_TICKS: accept and go HELD.
//         Key gone or different -> deb_cnt=0, go SCAN. The row does not rotate on this edge.
//   HELD: row frozen, key_held=1. col_n==4'hF -> go SCAN, rotate row on the same edge.
//         No auto-repeat; a different key in the same row while held is ignored until release.
//  Accept: key_code<=cand and key_valid=1 for exactly one clk, on the accepting edge only.
//   Registered: key_valid and the new key_code appear the cycle after the tick edge.
//  Entry register (same edge as accept):
//   code 0..9 -> bcd_t<=bcd_u, bcd_u<=code (shift-left); old tens dropped.
//   code F    -> bcd_t<=0, bcd_u<=0 (clear).
//   codes A..E -> entry register unchanged; key_valid still pulses.
//  Latency: from stable key at first sampling tick to key_valid = DEB_TICKS-1 further ticks + 1 clk.
//  scan_tick=0: all state, row_n and outputs hold; key_valid forced 0.
//  col_n is sampled directly; the board supplies synchronisation. Glitches shorter than DEB_TICKS ticks are rejected.
//  Reset mid-DEBOUNCE/HELD: no key_valid is emitted; scanning restarts at row 0.
// TESTING
//  1. Reset then idle cols 4'hF, 8 ticks -> row_n cycles 1110,1101,1011,0111,1110...; key_valid never 1.
//  2. Press '5' (r1,c1) held 3 ticks, DEB_TICKS=3 -> one key_valid, key_code=5, bcd_u=5, bcd_t=0, key_held=1.
//  3. Press/release 3 then 7 -> bcd_t=3, bcd_u=7. Then press 2 -> bcd_t=7, bcd_u=2.
//  4. Bounce: '8' low for 2 ticks, high, low again for 3 -> exactly one key_valid, key_code=8.
//  5. Press 'F' after entry 42 -> bcd_t=0, bcd_u=0, key_code=4'hF. Press 'A' -> key_valid pulses; bcd unchanged.
//  6. Hold '9' 20 ticks -> single key_valid. Assert rst mid-DEBOUNCE of '1' -> no pulse; row_n=1110, bcd=00.

Source files
------------

// File: rtl/keypad_bcd_if.sv
// keypad_bcd_if: keypad scan strobe, row/column lines and encoded key/BCD outputs
interface keypad_bcd_if;
  logic       scan_tick;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] bcd_u;
  logic [3:0] bcd_t;
  modport master(output scan_tick, col_n, input row_n, key_code, key_valid, key_held, bcd_u, bcd_t);
  modport slave(input scan_tick, col_n, output row_n, key_code, key_valid, key_held, bcd_u, bcd_t);
endinterface

// File: rtl/keypad_bcd_encoder.sv
// keypad_bcd_encoder: 4x4 keypad scanner with debounce, key encoding and two-digit BCD entry register
// clk, rst    : system clock, synchronous active-high reset
// kp.slave    : scan_tick/col_n in; row_n, key_code, key_valid, key_held, bcd_u, bcd_t out
module keypad_bcd_encoder #(
  parameter int DEB_TICKS = 3
) (
  input  logic         clk,
  input  logic         rst,
  keypad_bcd_if.slave  kp
);
  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };
  logic [1:0] r_state;
  logic [3:0] r_row;
  logic [3:0] r_deb;
  logic [3:0] r_cand;
  logic [3:0] r_code;
  logic       r_valid;
  logic [3:0] r_bcd_u;
  logic [3:0] r_bcd_t;
  logic [1:0] w_r;
  logic [1:0] w_c;
  logic [3:0] w_key;
  logic       w_press;
  logic       w_match;
  logic [4:0] w_deb_next;
  logic       w_deb_done;
  logic       w_accept;
  logic [3:0] w_acc_code;
  logic [3:0] w_row_rot;
  always_comb begin
    w_r        = !r_row[0] ? 2'd0 : !r_row[1] ? 2'd1 : !r_row[2] ? 2'd2 : 2'd3;
    // lowest low column wins when several keys in the driven row are down
    w_c        = !kp.col_n[0] ? 2'd0 : !kp.col_n[1] ? 2'd1 : !kp.col_n[2] ? 2'd2 : 2'd3;
    w_key      = KEY_MAP[{w_r, w_c}];
    w_press    = kp.col_n != 4'hF;
    w_match    = w_press && w_key == r_cand;
    w_deb_next = {1'b0, r_deb} + 5'd1;
    w_deb_done = w_deb_next == 5'(DEB_TICKS);
    w_accept   = kp.scan_tick && ((r_state == SCAN && w_press && DEB_TICKS == 1) ||
                                  (r_state == DEBOUNCE && w_match && w_deb_done));
    w_acc_code = r_state == SCAN ? w_key : r_cand;
    w_row_rot  = {r_row[2:0], r_row[3]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCAN;
      r_row   <= 4'b1110;
      r_deb   <= 4'd0;
      r_cand  <= 4'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_bcd_u <= 4'd0;
      r_bcd_t <= 4'd0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_code <= w_acc_code;
        if (w_acc_code <= 4'd9) begin
          r_bcd_t <= r_bcd_u;
          r_bcd_u <= w_acc_code;
        end else if (w_acc_code == 4'hF) begin
          r_bcd_t <= 4'd0;
          r_bcd_u <= 4'd0;
        end
      end
      if (kp.scan_tick) begin
        case (r_state)
          SCAN: begin
            if (!w_press) r_row <= w_row_rot;
            else begin
              r_cand  <= w_key;
              r_deb   <= 4'd1;
              r_state <= DEB_TICKS == 1 ? HELD : DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            // a lost or changed key re-samples the same row on the next tick
            if (!w_match) begin
              r_deb   <= 4'd0;
              r_state <= SCAN;
            end else begin
              r_deb   <= w_deb_next[3:0];
              r_state <= w_deb_done ? HELD : DEBOUNCE;
            end
          end
          HELD: begin
            if (!w_press) begin
              r_deb   <= 4'd0;
              r_row   <= w_row_rot;
              r_state <= SCAN;
            end
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end
  assign kp.row_n     = r_row;
  assign kp.key_code  = r_code;
  assign kp.key_valid = r_valid;
  assign kp.key_held  = r_state == HELD;
  assign kp.bcd_u     = r_bcd_u;
  assign kp.bcd_t     = r_bcd_t;
endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// tb_keypad_bcd_encoder: randomized and directed checks of keypad scanning, debounce and BCD entry
module tb_keypad_bcd_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  keypad_bcd_if kp();
  keypad_bcd_encoder #(.DEB_TICKS(3)) dut (.clk(clk), .rst(rst), .kp(kp));
  logic [1:0] p_row;
  logic [3:0] p_mask;
  assign kp.col_n = (p_mask != 4'd0 && kp.row_n[p_row] == 1'b0) ? ~p_mask : 4'hF;
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
  int checks = 0;
  int errors = 0;
  int n_pulse = 0;
  int m_val = 0;
  logic [3:0] last_code = 4'd0;
  logic prev_kv = 1'b0;
  always @(posedge clk) begin
    #1;
    if (kp.key_valid === 1'b1) begin
      n_pulse++;
      last_code = kp.key_code;
      checks++;
      if (prev_kv) begin
        errors++;
        $display("FAIL pulse_width key_valid high two cycles in a row, required one");
      end
    end
    prev_kv = kp.key_valid;
  end
  function automatic logic [1:0] low_col(input logic [3:0] m);
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) low_col = 2'(i);
  endfunction
  task automatic tick(input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk) kp.scan_tick = 1'b1;
    @(negedge clk) kp.scan_tick = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    m_val = 0;
  endtask
  task automatic model_accept(input logic [3:0] code);
    if (code <= 4'd9) m_val = (m_val % 10) * 10 + int'(code);
    else if (code == 4'hF) m_val = 0;
  endtask
  task automatic check_bcd(input string name);
    logic [7:0] exp;
    exp = {4'(m_val / 10), 4'(m_val % 10)};
    checks++;
    if ({kp.bcd_t, kp.bcd_u} !== exp) begin
      errors++;
      $display("FAIL %s bcd got %h required %h", name, {kp.bcd_t, kp.bcd_u}, exp);
    end
  endtask
  task automatic release_key(input string name);
    p_mask = 4'd0;
    tick(0);
    checks++;
    if (kp.key_held !== 1'b0) begin
      errors++;
      $display("FAIL %s release key_held got %b required 0", name, kp.key_held);
    end
    tick(0);
  endtask
  task automatic press_mask(input logic [1:0] r, input logic [3:0] mask, input int hold, input string name);
    int n0, exp_n;
    logic [3:0] exp_code;
    n0 = n_pulse;
    exp_code = keymap[{r, low_col(mask)}];
    exp_n = hold >= 6 ? 1 : 0;
    p_row = r;
    p_mask = mask;
    repeat (hold) tick($urandom_range(0, 2));
    checks++;
    if (n_pulse - n0 !== exp_n) begin
      errors++;
      $display("FAIL %s pulses got %0d required %0d", name, n_pulse - n0, exp_n);
    end
    if (exp_n == 1) begin
      model_accept(exp_code);
      checks++;
      if (last_code !== exp_code) begin
        errors++;
        $display("FAIL %s key_code got %h required %h", name, last_code, exp_code);
      end
      checks++;
      if (kp.key_held !== 1'b1) begin
        errors++;
        $display("FAIL %s key_held got %b required 1", name, kp.key_held);
      end
    end
    check_bcd(name);
    release_key(name);
  endtask
  task automatic press_key(input logic [3:0] code, input int hold, input string name);
    for (int i = 0; i < 16; i++)
      if (keymap[i] == code) press_mask(2'(i / 4), 4'b0001 << (i % 4), hold, name);
  endtask
  task automatic goto_row(input int r);
    int b;
    b = 0;
    p_mask = 4'd0;
    while (kp.row_n[r] !== 1'b0 && b < 8) begin
      tick(0);
      b++;
    end
    checks++;
    if (kp.row_n[r] !== 1'b0) begin
      errors++;
      $display("FAIL goto_row row_n got %b required row %0d low", kp.row_n, r);
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({kp.row_n, kp.key_code, kp.key_valid, kp.key_held, kp.bcd_t, kp.bcd_u} !== {4'b1110, 4'h0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset row %b code %h kv %b held %b bcd %h%h required 1110 0 0 0 00",
               kp.row_n, kp.key_code, kp.key_valid, kp.key_held, kp.bcd_t, kp.bcd_u);
    end
  endtask
  task automatic test_idle();
    int idx, n0;
    logic [3:0] exp, hold_row;
    idx = 0;
    n0 = n_pulse;
    for (int i = 0; i < 8; i++) begin
      tick(0);
      idx = (idx + 1) % 4;
      exp = ~(4'b0001 << idx);
      checks++;
      if (kp.row_n !== exp) begin
        errors++;
        $display("FAIL idle_rotate step %0d row_n got %b required %b", i, kp.row_n, exp);
      end
    end
    hold_row = kp.row_n;
    repeat (5) @(negedge clk);
    checks++;
    if (kp.row_n !== hold_row || n_pulse !== n0) begin
      errors++;
      $display("FAIL idle_hold row_n got %b required %b pulses %0d required 0", kp.row_n, hold_row, n_pulse - n0);
    end
  endtask
  task automatic test_latency();
    int n0;
    do_reset();
    n0 = n_pulse;
    p_row = 2'd0;
    p_mask = 4'b0010;
    tick(0);
    tick(0);
    checks++;
    if (n_pulse !== n0 || kp.key_held !== 1'b0) begin
      errors++;
      $display("FAIL latency_early pulses %0d held %b required 0 0", n_pulse - n0, kp.key_held);
    end
    tick(0);
    model_accept(4'h2);
    checks++;
    if (n_pulse !== n0 + 1 || last_code !== 4'h2 || kp.key_held !== 1'b1) begin
      errors++;
      $display("FAIL latency_accept pulses %0d code %h held %b required 1 2 1", n_pulse - n0, last_code, kp.key_held);
    end
    @(negedge clk);
    checks++;
    if (kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_pulse key_valid got %b required 0", kp.key_valid);
    end
    check_bcd("latency");
    release_key("latency");
  endtask
  task automatic test_entry();
    do_reset();
    press_key(4'h5, 6, "press5");
    press_key(4'h3, 7, "press3");
    press_key(4'h7, 6, "press7");
    checks++;
    if ({kp.bcd_t, kp.bcd_u} !== 8'h37) begin
      errors++;
      $display("FAIL entry37 got %h%h required 37", kp.bcd_t, kp.bcd_u);
    end
    press_key(4'h2, 8, "press2");
    checks++;
    if ({kp.bcd_t, kp.bcd_u} !== 8'h72) begin
      errors++;
      $display("FAIL entry72 got %h%h required 72", kp.bcd_t, kp.bcd_u);
    end
  endtask
  task automatic test_bounce();
    int n0;
    goto_row(2);
    n0 = n_pulse;
    p_row = 2'd2;
    p_mask = 4'b0010;
    tick(0);
    tick(0);
    p_mask = 4'd0;
    tick(0);
    p_mask = 4'b0010;
    tick(0);
    tick(0);
    checks++;
    if (n_pulse !== n0) begin
      errors++;
      $display("FAIL bounce_early pulses got %0d required 0", n_pulse - n0);
    end
    tick(0);
    model_accept(4'h8);
    checks++;
    if (n_pulse !== n0 + 1 || last_code !== 4'h8) begin
      errors++;
      $display("FAIL bounce_accept pulses %0d code %h required 1 8", n_pulse - n0, last_code);
    end
    release_key("bounce");
  endtask
  task automatic test_clear_letters();
    press_key(4'h4, 6, "press4");
    press_key(4'h2, 6, "press2b");
    checks++;
    if ({kp.bcd_t, kp.bcd_u} !== 8'h42) begin
      errors++;
      $display("FAIL entry42 got %h%h required 42", kp.bcd_t, kp.bcd_u);
    end
    press_key(4'hF, 6, "pressF");
    checks++;
    if ({kp.bcd_t, kp.bcd_u, last_code} !== 12'h00F) begin
      errors++;
      $display("FAIL clear got bcd %h%h code %h required 00 F", kp.bcd_t, kp.bcd_u, last_code);
    end
    press_key(4'h6, 6, "press6");
    press_key(4'hA, 6, "pressA");
  endtask
  task automatic test_multi();
    int n0;
    press_mask(2'd1, 4'b0101, 6, "multi_r1");
    press_mask(2'd3, 4'b1100, 7, "multi_r3");
    n0 = n_pulse;
    p_row = 2'd1;
    p_mask = 4'b0010;
    repeat (6) tick(0);
    model_accept(4'h5);
    p_mask = 4'b0011;
    repeat (5) tick(1);
    checks++;
    if (n_pulse !== n0 + 1 || last_code !== 4'h5 || kp.key_held !== 1'b1) begin
      errors++;
      $display("FAIL held_ignore pulses %0d code %h held %b required 1 5 1", n_pulse - n0, last_code, kp.key_held);
    end
    check_bcd("held_ignore");
    release_key("held_ignore");
  endtask
  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [3:0] code;
      int hold;
      code = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : $urandom_range(6, 10);
      press_key(code, hold, "random");
    end
  endtask
  task automatic test_reset_mid();
    int n0;
    press_key(4'h9, 20, "hold9");
    goto_row(0);
    p_row = 2'd0;
    p_mask = 4'b0001;
    tick(0);
    n0 = n_pulse;
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (n_pulse !== n0 || {kp.row_n, kp.key_held, kp.key_code, kp.bcd_t, kp.bcd_u} !== {4'b1110, 1'b0, 12'h000}) begin
      errors++;
      $display("FAIL reset_mid pulses %0d row %b held %b code %h bcd %h%h required 0 1110 0 0 00",
               n_pulse - n0, kp.row_n, kp.key_held, kp.key_code, kp.bcd_t, kp.bcd_u);
    end
    p_mask = 4'd0;
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    kp.scan_tick = 1'b0;
    p_row = 2'd0;
    p_mask = 4'd0;
    test_reset();
    test_idle();
    test_latency();
    test_entry();
    test_bounce();
    test_clear_letters();
    test_multi();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
